param_fancy_timer: RTL and testbench
====================================

PARAM_FANCY_TIMER -- requirements
Module: param_fancy_timer

Interface
REQ-001 SHALL have parameter PAT_W, default 4: start-pattern length in bits, at least 1.
REQ-002 SHALL have parameter PATTERN, default 4'b1101 (PAT_W bits): start pattern, oldest bit first (MSB).
REQ-003 SHALL have parameter DLY_W, default 4: delay-field width in bits, at least 1.
REQ-004 SHALL have parameter TICK, default 1000: cycles per count unit, at least 2.
REQ-005 SHALL have port clk  input  1: clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port data  input  1: serial pattern and delay stream.
REQ-008 SHALL have port ack  input  1: user acknowledge of done.
REQ-009 SHALL have port abort  input  1: cancels an in-progress load or count.
REQ-010 SHALL have port count  output  DLY_W: remaining whole units.
REQ-011 SHALL have port counting  output  1: high while in COUNT.
REQ-012 SHALL have port done  output  1: high while in DONE.

Function
REQ-013 SHALL implement four states: IDLE, LOAD, COUNT, DONE.
REQ-014 IDLE SHALL shift data into a PAT_W-bit window each cycle, newest bit in the LSB.
REQ-015 IDLE SHALL move to LOAD on the edge where the updated window equals PATTERN; overlapping matches SHALL be detected.
REQ-016 LOAD SHALL last exactly DLY_W cycles, shifting data MSB-first into a DLY_W-bit delay register; then COUNT.
REQ-017 COUNT SHALL last exactly (delay+1)*TICK cycles; then DONE.
REQ-018 COUNT SHALL use a tick counter of width $clog2(TICK) counting 0..TICK-1, and the delay register SHALL decrement when the tick counter wraps.
REQ-019 COUNT SHALL exit when delay==0 and the tick counter == TICK-1.
REQ-020 count SHALL show the delay register value while counting=1, and SHALL be 0 otherwise; it SHALL never be X.
REQ-021 DONE SHALL hold until ack is sampled high, then go to IDLE on the next edge.
REQ-022 Entry to IDLE SHALL clear the pattern window to all zeros, so a fresh full pattern is required.
REQ-023 abort sampled high in LOAD or COUNT SHALL force IDLE on the next edge with no done pulse; the delay and tick counters SHALL clear.
REQ-024 abort SHALL be ignored in IDLE and DONE; in DONE only ack releases.
REQ-025 ack SHALL be ignored outside DONE.
REQ-026 delay value 0 SHALL give exactly TICK counting cycles; all-ones SHALL give 2^DLY_W*TICK cycles, with no wrap.
REQ-027 counting and done SHALL be Moore outputs from registered state, mutually exclusive.

Reset
REQ-028 reset SHALL take priority over abort, ack and data.
REQ-029 reset SHALL set state=IDLE, window=0, delay=0, tick counter=0, count=0, counting=0, done=0 on the next edge.
REQ-030 reset asserted mid-LOAD or mid-COUNT SHALL abandon the operation with no done.

Structure
REQ-031 A shared package param_fancy_timer_pkg SHALL hold the state enum and the default PAT_W/PATTERN/DLY_W/TICK constants.
REQ-032 One sub-module, param_timer_tick, SHALL implement the tick counter and wrap/terminal flags, parametrised by TICK.
REQ-033 An elaboration-time check SHALL reject TICK<2, PAT_W<1 or DLY_W<1.

Verification (PAT_W=4, PATTERN=1101, DLY_W=4, TICK=4)
REQ-034 data 1,1,0,1 then 0,1,0,1 -> counting high 24 cycles, count 5,5,5,5,4,...,0; then done=1 until ack; IDLE next edge.
REQ-035 data 1,1,1,0,1 (overlap) then 0000 -> LOAD after the fifth bit; counting high exactly 4 cycles.
REQ-036 Delay 1111 -> counting high 64 cycles, count starts at 15, no wrap.
REQ-037 abort pulsed on the 7th COUNT cycle -> counting low next edge, done never asserted, count=0; new 1101 restarts.
REQ-038 ack and abort both high in DONE -> IDLE next edge; ack high in COUNT -> ignored, full count completes.
REQ-039 reset pulsed mid-LOAD -> all outputs 0 next edge; the trailing delay bits do not start a count.

Source files
------------

// File: rtl/param_fancy_timer_pkg.sv
// Shared types and default constants for the pattern-started delay timer.
// Imported by the timer top and its tick counter.
package param_fancy_timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_DONE
  } state_t;

  localparam int          DEF_PAT_W   = 4;
  localparam logic [3:0]  DEF_PATTERN = 4'b1101;
  localparam int          DEF_DLY_W   = 4;
  localparam int          DEF_TICK    = 1000;

endpackage

// File: rtl/param_fancy_timer_tick.sv
// Free-running 0..TICK-1 unit counter, only advancing while enabled.
// wrap marks the last cycle of a unit.
module param_timer_tick
  import param_fancy_timer_pkg::*;
#(
  parameter int TICK = DEF_TICK
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic wrap
);

  localparam int TW = $clog2(TICK);
  localparam logic [TW-1:0] LAST = TW'(TICK - 1);

  logic [TW-1:0] cnt_q;

  assign wrap = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= wrap ? '0 : cnt_q + TW'(1);
    end
  end

endmodule

// File: rtl/param_fancy_timer.sv
// Serial-armed timer: a start pattern, then a DLY_W-bit delay, then
// (delay+1)*TICK counting cycles before done is raised until ack.
module param_fancy_timer
  import param_fancy_timer_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               DLY_W   = DEF_DLY_W,
  parameter int               TICK    = DEF_TICK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data,
  input  logic             ack,
  input  logic             abort,
  output logic [DLY_W-1:0] count,
  output logic             counting,
  output logic             done
);

  if (TICK < 2 || PAT_W < 1 || DLY_W < 1) begin : g_bad_params
    $error("param_fancy_timer: need TICK>=2, PAT_W>=1, DLY_W>=1");
  end

  localparam int LW = $clog2(DLY_W + 1);
  localparam logic [LW-1:0] LD_LAST = LW'(DLY_W - 1);

  state_t state_q;
  state_t state_d;

  logic [PAT_W-1:0] window_q;
  logic [PAT_W:0]   win_shift;
  logic             match;

  logic [DLY_W-1:0] delay_q;
  logic [DLY_W:0]   dly_shift;
  logic             dly_zero;

  logic [LW-1:0]    ld_cnt_q;
  logic             ld_last;

  logic             abort_hit;
  logic             tick_wrap;

  assign win_shift = {window_q, data};
  assign match     = win_shift[PAT_W-1:0] == PATTERN;
  assign dly_shift = {delay_q, data};
  assign dly_zero  = delay_q == '0;
  assign ld_last   = ld_cnt_q == LD_LAST;

  assign abort_hit = abort &&
    (state_q == S_LOAD || state_q == S_COUNT);

  param_timer_tick #(
    .TICK (TICK)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (abort_hit),
    .en    (state_q == S_COUNT),
    .wrap  (tick_wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (match) state_d = S_LOAD;
      S_LOAD:  begin
        if (abort)        state_d = S_IDLE;
        else if (ld_last) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (abort)                      state_d = S_IDLE;
        else if (tick_wrap && dly_zero) state_d = S_DONE;
      end
      S_DONE:  if (ack) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Window restarts empty on every return to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      window_q <= '0;
    end else if (state_q == S_IDLE) begin
      window_q <= win_shift[PAT_W-1:0];
    end else if (state_d == S_IDLE) begin
      window_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      delay_q  <= '0;
      ld_cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          ld_cnt_q <= '0;
        end
        S_LOAD: begin
          if (abort) begin
            delay_q  <= '0;
            ld_cnt_q <= '0;
          end else begin
            delay_q  <= dly_shift[DLY_W-1:0];
            ld_cnt_q <= ld_last ? '0 : ld_cnt_q + LW'(1);
          end
        end
        S_COUNT: begin
          if (abort) begin
            delay_q <= '0;
          end else if (tick_wrap && !dly_zero) begin
            delay_q <= delay_q - DLY_W'(1);
          end
        end
        S_DONE: begin
          delay_q <= '0;
        end
      endcase
    end
  end

  assign counting = state_q == S_COUNT;
  assign done     = state_q == S_DONE;
  assign count    = counting ? delay_q : '0;

endmodule

// File: tb/tb_param_fancy_timer.sv
// Randomized bench for param_fancy_timer against a cycle-count model.
// Small TICK keeps full counts short.
module tb_param_fancy_timer;

  localparam int         PAT_W   = 4;
  localparam logic [3:0] PATTERN = 4'b1101;
  localparam int         DLY_W   = 4;
  localparam int         TICK    = 4;
  localparam int         PMASK   = (1 << PAT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             data;
  logic             ack;
  logic             abort;
  logic [DLY_W-1:0] count;
  logic             counting;
  logic             done;

  int total = 0;
  int bad   = 0;
  int hist  = 0;

  always #5 clk = ~clk;

  param_fancy_timer #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .DLY_W   (DLY_W),
    .TICK    (TICK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .ack      (ack),
    .abort    (abort),
    .count    (count),
    .counting (counting),
    .done     (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bit(input bit b, output bit hit);
    data = b;
    hist = ((hist << 1) | int'(b)) & PMASK;
    hit  = hist == int'(PATTERN);
    step();
  endtask

  task automatic noise(input int n);
    bit b;
    bit hit;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      if ((((hist << 1) | int'(b)) & PMASK) == int'(PATTERN)) b = !b;
      ack   = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      idle_bit(b, hit);
      total++;
      if (counting !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL idle_quiet: counting=%b done=%b want 0 0",
                 counting, done);
      end
    end
    ack   = 1'b0;
    abort = 1'b0;
  endtask

  task automatic send_pattern();
    bit hit;
    for (int i = PAT_W - 1; i >= 0; i--) begin
      idle_bit(PATTERN[i], hit);
      if (hit) break;
    end
  endtask

  task automatic load_delay(input int d);
    for (int i = DLY_W - 1; i >= 0; i--) begin
      data = 1'((d >> i) & 1);
      step();
      if (i > 0) begin
        total++;
        if (counting !== 1'b0) begin
          bad++;
          $display("FAIL load_quiet: counting=%b want 0", counting);
        end
      end
    end
    hist = 0;
  endtask

  task automatic run_count(input int d, input int abort_at,
                           input bit ack_noise);
    int n;
    int exp;
    n = (d + 1) * TICK;
    for (int k = 0; k < n; k++) begin
      exp = d - k / TICK;
      total++;
      if (counting !== 1'b1 || count !== DLY_W'(exp) || done !== 1'b0) begin
        bad++;
        $display("FAIL count_k%0d: counting=%b count=%0d done=%b want 1 %0d 0",
                 k, counting, count, done, exp);
      end
      abort = (k == abort_at);
      ack   = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      data  = 1'($urandom_range(0, 1));
      step();
      if (k == abort_at) begin
        abort = 1'b0;
        ack   = 1'b0;
        hist  = 0;
        total++;
        if (counting !== 1'b0 || count !== '0 || done !== 1'b0) begin
          bad++;
          $display("FAIL abort: counting=%b count=%0d done=%b want 0 0 0",
                   counting, count, done);
        end
        return;
      end
    end
    abort = 1'b0;
    ack   = 1'b0;
    total++;
    if (done !== 1'b1 || counting !== 1'b0 || count !== '0) begin
      bad++;
      $display("FAIL done_entry: done=%b counting=%b count=%0d want 1 0 0",
               done, counting, count);
    end
  endtask

  task automatic finish_done(input bit with_abort);
    int hold;
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      abort = 1'($urandom_range(0, 1));
      data  = 1'($urandom_range(0, 1));
      step();
      total++;
      if (done !== 1'b1 || counting !== 1'b0) begin
        bad++;
        $display("FAIL done_hold: done=%b counting=%b want 1 0",
                 done, counting);
      end
    end
    ack   = 1'b1;
    abort = with_abort;
    step();
    ack   = 1'b0;
    abort = 1'b0;
    hist  = 0;
    total++;
    if (done !== 1'b0 || counting !== 1'b0 || count !== '0) begin
      bad++;
      $display("FAIL ack_release: done=%b counting=%b count=%0d want 0 0 0",
               done, counting, count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data  = 1'($urandom_range(0, 1));
      ack   = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      step();
    end
    total++;
    if (count !== '0 || counting !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset: count=%0d counting=%b done=%b want 0 0 0",
               count, counting, done);
    end
    reset = 1'b0;
    data  = 1'b0;
    ack   = 1'b0;
    abort = 1'b0;
    hist  = 0;
  endtask

  task automatic test_basic();
    send_pattern();
    load_delay(5);
    run_count(5, -1, 1'b0);
    finish_done(1'b0);
  endtask

  task automatic test_overlap();
    bit hit;
    idle_bit(1'b1, hit);
    send_pattern();
    load_delay(0);
    run_count(0, -1, 1'b0);
    finish_done(1'b0);
  endtask

  task automatic test_max_delay();
    send_pattern();
    load_delay(15);
    run_count(15, -1, 1'b0);
    finish_done(1'b0);
  endtask

  task automatic test_random();
    int d;
    for (int r = 0; r < 6; r++) begin
      d = $urandom_range(0, (1 << DLY_W) - 1);
      noise($urandom_range(0, 6));
      send_pattern();
      load_delay(d);
      run_count(d, -1, 1'b1);
      finish_done(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_abort();
    int d;
    d = $urandom_range(2, (1 << DLY_W) - 1);
    send_pattern();
    load_delay(d);
    run_count(d, 6, 1'b0);
    noise(8);
    d = $urandom_range(0, 6);
    send_pattern();
    load_delay(d);
    run_count(d, -1, 1'b0);
    finish_done(1'b0);
  endtask

  task automatic test_done_ack_abort();
    send_pattern();
    load_delay(1);
    run_count(1, -1, 1'b1);
    finish_done(1'b1);
  endtask

  task automatic test_reset_midload();
    bit hit;
    send_pattern();
    data = 1'b1;
    step();
    data = 1'b0;
    step();
    reset = 1'b1;
    data  = 1'b1;
    step();
    reset = 1'b0;
    hist  = 0;
    total++;
    if (count !== '0 || counting !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_midload: count=%0d counting=%b done=%b want 0 0 0",
               count, counting, done);
    end
    idle_bit(1'b0, hit);
    idle_bit(1'b1, hit);
    noise(10);
  endtask

  initial begin
    reset = 1'b1;
    data  = 1'b0;
    ack   = 1'b0;
    abort = 1'b0;
    test_reset();
    test_basic();
    test_overlap();
    test_max_delay();
    test_random();
    test_abort();
    test_done_ack_abort();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
